// File: rtl/hwag_pkg.sv
// Shared definitions for the hwag capture path: default period width,
// edge-select encoding and the capture bundle handed to hwag.
package hwag_pkg;

   localparam int unsigned HWAG_PER_W = 24;

   localparam logic EDGE_RISE = 1'b0;
   localparam logic EDGE_FALL = 1'b1;

   typedef struct packed {
      logic                  cap_stb;
      logic [HWAG_PER_W-1:0] cap_per;
      logic                  per_valid;
   } hwag_cap_t;

   // True when a level change to new_lvl is the edge polarity chosen by edge_sel.
   function automatic logic sel_edge_hit(input logic new_lvl, input logic edge_sel);
      return (edge_sel == EDGE_RISE) ? new_lvl : !new_lvl;
   endfunction

endpackage

// File: rtl/hwag_sync.sv
// N-flop synchroniser for asynchronous single-bit inputs; resets to 0.
// STAGES must be at least 2.
module hwag_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw input through the synchroniser chain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hwag_cap_filter.sv
// Crank VR capture conditioner: synchronise, glitch-filter, qualify the
// selected edge against a minimum tooth period and measure the period.
module hwag_cap_filter
   import hwag_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_W      = 8,
   parameter int unsigned PER_W       = HWAG_PER_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_in,
   input  logic [FILT_W-1:0] filt_len,
   input  logic              edge_sel,
   input  logic [PER_W-1:0]  min_per,
   output logic              cap_out,
   output logic              cap_stb,
   output logic              rej_stb,
   output logic [PER_W-1:0]  cap_per,
   output logic              per_valid,
   output logic              per_ovf
);

   localparam logic [PER_W-1:0]  PC_MAX   = '1;
   localparam logic [PER_W-1:0]  PC_ONE   = PER_W'(1);
   localparam logic [FILT_W-1:0] FILT_ONE = FILT_W'(1);

   logic              s;
   logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
   logic              cap_out_d;
   logic              toggle;

   logic [PER_W-1:0]  pc_q, pc_d, pc_inc;
   logic              first_q, first_d;
   logic              edge_ev, accept, reject;
   logic [PER_W-1:0]  cap_per_d;
   logic              per_valid_d, per_ovf_d;

   hwag_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (cap_in),
      .q   (s)
   );

   // Glitch filter: a level change needs filt_len+1 consecutive differing samples.
   // The >= compare lets a reduced filt_len take effect on the next differing sample.
   always_comb begin
      toggle     = 1'b0;
      filt_cnt_d = '0;
      cap_out_d  = cap_out;
      if (s != cap_out) begin
         if (filt_cnt_q >= filt_len) begin
            toggle    = 1'b1;
            cap_out_d = s;
         end else begin
            filt_cnt_d = filt_cnt_q + FILT_ONE;
         end
      end
   end

   // Edge qualification against min_per and saturating period bookkeeping.
   always_comb begin
      edge_ev     = toggle && sel_edge_hit(s, edge_sel);
      accept      = edge_ev && (first_q || (pc_q >= min_per));
      reject      = edge_ev && !accept;
      pc_inc      = (pc_q == PC_MAX) ? PC_MAX : pc_q + PC_ONE;
      pc_d        = pc_inc;
      first_d     = first_q;
      cap_per_d   = cap_per;
      per_valid_d = per_valid;
      per_ovf_d   = per_ovf || (pc_inc == PC_MAX);
      if (accept) begin
         pc_d      = PC_ONE;
         first_d   = 1'b0;
         per_ovf_d = 1'b0;
         // The first edge only starts the measurement; there is no period yet.
         if (!first_q) begin
            cap_per_d   = pc_q;
            per_valid_d = 1'b1;
         end
      end
   end

   // Filter state and filtered level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt_cnt_q <= '0;
         cap_out    <= 1'b0;
      end else begin
         filt_cnt_q <= filt_cnt_d;
         cap_out    <= cap_out_d;
      end
   end

   // Period counter, first-edge flag, strobes and measurement outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q      <= '0;
         first_q   <= 1'b1;
         cap_stb   <= 1'b0;
         rej_stb   <= 1'b0;
         cap_per   <= '0;
         per_valid <= 1'b0;
         per_ovf   <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         first_q   <= first_d;
         cap_stb   <= accept;
         rej_stb   <= reject;
         cap_per   <= cap_per_d;
         per_valid <= per_valid_d;
         per_ovf   <= per_ovf_d;
      end
   end

   // Accept and reject come from the same edge event and never coincide.
   assert property (@(posedge clk) disable iff (!rst) !(cap_stb && rej_stb));

endmodule
